mram_burst_ctrl: RTL

- Synchronous burst controller sitting directly upstream of MRAM_model; owns every MRAM strobe, address and write-data pin.
- Accepts one burst command (read/write, start address, length) through a valid/ready handshake.
- Streams write words in through a valid/ready port and streams read words out as single-cycle valid pulses, so the STP/PTS datapath never drives MRAM pins directly.

---
 rtl/mram_burst_ctrl_if.sv | 30 +++
 rtl/mram_burst_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mram_burst_ctrl_if.sv
// Command / write-stream / read-stream bundle between the datapath and mram_burst_ctrl.
// The datapath is the master; the controller is the slave.
interface mram_burst_ctrl_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic              done;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid,
        input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid,
        output cmd_ready, wr_ready, rd_data, rd_valid, busy, done
    );
endinterface

// File: rtl/mram_burst_ctrl.sv
// Burst controller owning all MRAM pins: one command per burst, words streamed in/out,
// every strobe, address and write-data pin registered.
module mram_burst_ctrl #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 16,
    parameter int LEN_W   = 8,
    parameter int WR_HOLD = 1,
    parameter int RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    mram_burst_ctrl_if.slave  bus,
    output logic              e_chipEnable_n,
    output logic              g_outputEnable_n,
    output logic              w_writeEnable_n,
    output logic              lb_lowerByteEnable_n,
    output logic              ub_upperByteEnable_n,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] dqi_datainput,
    input  logic [DATA_W-1:0] dqo_dataoutput
);
    localparam int HOLD_MAX = (WR_HOLD > RD_LAT + 1) ? WR_HOLD : RD_LAT + 1;
    localparam int CNT_W    = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    // Strobe vector order: {E, G, W, LB, UB}
    localparam logic [4:0] STB_IDLE  = 5'b11111;
    localparam logic [4:0] STB_WRITE = 5'b01000;
    localparam logic [4:0] STB_READ  = 5'b00100;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WR_WAIT    = 3'd1,
        ST_WR_STROBE  = 3'd2,
        ST_WR_RECOVER = 3'd3,
        ST_RD_STROBE  = 3'd4,
        ST_RD_RECOVER = 3'd5,
        ST_DONE       = 3'd6
    } state_t;

    state_t            state_r, state_s;
    logic [LEN_W-1:0]  remaining_r, remaining_s;
    logic [CNT_W-1:0]  hold_cnt_r, hold_cnt_s;
    logic [ADDR_W-1:0] address_r, address_s;
    logic [DATA_W-1:0] dqi_r, dqi_s;
    logic [DATA_W-1:0] rd_data_r, rd_data_s;
    logic              rd_valid_r, rd_valid_s;
    logic              done_r, done_s;
    logic [4:0]        strobe_r, strobe_s;

    // Next-state and next-output computation; registered outputs follow the next state.
    always_comb begin
        state_s     = state_r;
        remaining_s = remaining_r;
        hold_cnt_s  = hold_cnt_r;
        address_s   = address_r;
        dqi_s       = dqi_r;
        rd_data_s   = rd_data_r;
        rd_valid_s  = 1'b0;
        done_s      = 1'b0;
        strobe_s    = STB_IDLE;

        case (state_r)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    address_s   = bus.cmd_addr;
                    remaining_s = bus.cmd_len;
                    hold_cnt_s  = {CNT_W{1'b0}};
                    state_s     = bus.cmd_write ? ST_WR_WAIT : ST_RD_STROBE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WR_WAIT: begin
                if (bus.wr_valid) begin
                    dqi_s      = bus.wr_data;
                    hold_cnt_s = {CNT_W{1'b0}};
                    state_s    = ST_WR_STROBE;
                end else begin
                    state_s = ST_WR_WAIT;
                end
            end
            ST_WR_STROBE: begin
                if (hold_cnt_r == CNT_W'(WR_HOLD - 1)) begin
                    state_s = ST_WR_RECOVER;
                end else begin
                    hold_cnt_s = hold_cnt_r + CNT_W'(1);
                end
            end
            ST_RD_STROBE: begin
                // Data is sampled on the edge that ends the final strobe cycle.
                if (hold_cnt_r == CNT_W'(RD_LAT)) begin
                    rd_data_s  = dqo_dataoutput;
                    rd_valid_s = 1'b1;
                    state_s    = ST_RD_RECOVER;
                end else begin
                    hold_cnt_s = hold_cnt_r + CNT_W'(1);
                end
            end
            ST_WR_RECOVER, ST_RD_RECOVER: begin
                if (remaining_r == {LEN_W{1'b0}}) begin
                    state_s = ST_DONE;
                end else begin
                    remaining_s = remaining_r - LEN_W'(1);
                    address_s   = address_r + ADDR_W'(1);
                    hold_cnt_s  = {CNT_W{1'b0}};
                    state_s     = (state_r == ST_WR_RECOVER) ? ST_WR_WAIT : ST_RD_STROBE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        case (state_s)
            ST_WR_STROBE: strobe_s = STB_WRITE;
            ST_RD_STROBE: strobe_s = STB_READ;
            default:      strobe_s = STB_IDLE;
        endcase

        if (state_s == ST_DONE) begin
            done_s = 1'b1;
        end else begin
            done_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and pin registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining_r <= {LEN_W{1'b0}};
            hold_cnt_r  <= {CNT_W{1'b0}};
            address_r   <= {ADDR_W{1'b0}};
            dqi_r       <= {DATA_W{1'b0}};
            rd_data_r   <= {DATA_W{1'b0}};
            rd_valid_r  <= 1'b0;
            done_r      <= 1'b0;
            strobe_r    <= STB_IDLE;
        end else begin
            remaining_r <= remaining_s;
            hold_cnt_r  <= hold_cnt_s;
            address_r   <= address_s;
            dqi_r       <= dqi_s;
            rd_data_r   <= rd_data_s;
            rd_valid_r  <= rd_valid_s;
            done_r      <= done_s;
            strobe_r    <= strobe_s;
        end
    end

    assign bus.cmd_ready = (state_r == ST_IDLE);
    assign bus.wr_ready  = (state_r == ST_WR_WAIT);
    assign bus.busy      = (state_r != ST_IDLE);
    assign bus.done      = done_r;
    assign bus.rd_data   = rd_data_r;
    assign bus.rd_valid  = rd_valid_r;

    assign e_chipEnable_n       = strobe_r[4];
    assign g_outputEnable_n     = strobe_r[3];
    assign w_writeEnable_n      = strobe_r[2];
    assign lb_lowerByteEnable_n = strobe_r[1];
    assign ub_upperByteEnable_n = strobe_r[0];
    assign address              = address_r;
    assign dqi_datainput        = dqi_r;
endmodule
